rng_word_gen: RTL and testbench
===============================

Name: rng_word_gen

Overview:
Parametrised pseudo-random word generator and the successor to the fixed 6-bit serial generator. A Fibonacci LFSR of configurable length and taps produces STEPS bits per enabled cycle, which are assembled into WIDTH-bit words. Words outside an inclusive runtime range limit are rejected, and accepted words are delivered over a valid/ready handshake with backpressure. The block feeds game logic that needs bounded random values, such as positions and events.

Parameters:
WIDTH, 6, output word width in bits (2..32)
LFSR_W, 16, LFSR length in bits (WIDTH..32)
TAPS, 16'hB400, feedback mask; bit i set means lfsr[i] is XORed into feedback
STEPS, 1, LFSR steps and bits gathered per enabled cycle; WIDTH % STEPS must be 0
RESET_SEED, 16'hACE1, LFSR value after reset; must be non-zero

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  advances the LFSR and assembly while high
seed_load  in  1  one-cycle pulse that loads seed
seed  in  LFSR_W  new LFSR state
limit  in  WIDTH  inclusive upper bound for accepted words; all-ones disables rejection
out_data  out  WIDTH  random word, held stable while out_valid=1
out_valid  out  1  out_data is valid
out_ready  in  1  consumer accepts the word when out_valid && out_ready
rej_cnt  out  8  saturating count of rejected candidates since reset or seed_load

Behaviour:
- Reset (async, rst_n=0):
  - lfsr=RESET_SEED, acc=0, bit_cnt=0, state=FILL.
  - out_data=0, out_valid=0, rej_cnt=0.
- One LFSR step:
  - fb = XOR-reduce(lfsr & TAPS); lfsr <= {lfsr[LFSR_W-2:0], fb}.
  - The generated bit is fb.
  - For STEPS>1, steps are chained combinationally; the first generated bit enters acc first.
- Assembly: acc shifts left and new bits enter at the LSB, so the earliest bit ends at the MSB.
- FSM states: FILL and STALL.
- FILL, en=1:
  - Perform STEPS LFSR steps; bit_cnt += STEPS.
  - When bit_cnt reaches WIDTH, the candidate is the full acc including this cycle's bits.
  - If candidate > limit: discard it, increment rej_cnt (saturating at 255), set bit_cnt=0, stay in FILL.
  - If candidate <= limit and the output slot is free (out_valid=0, or a handshake occurs this cycle): out_data<=candidate, out_valid<=1, bit_cnt=0.
  - If candidate <= limit and the slot is occupied with no handshake: go to STALL and hold the candidate.
- FILL, en=0: everything holds.
- STALL:
  - LFSR and acc freeze regardless of en.
  - On handshake: out_data<=held candidate, out_valid stays 1, go to FILL.
- Handshake with no new candidate: out_valid<=0 on the next edge.
- limit is sampled only in the cycle the candidate completes.
- Latency: from reset release with en=1, out_ready=1 and limit=all-ones, out_valid rises at the WIDTH/STEPS-th edge. Sustained throughput is one word per WIDTH/STEPS enabled cycles.
- seed_load has priority over en and the handshake:
  - lfsr<=seed; if seed==0, lfsr<=1 instead (lock-up guard).
  - acc=0, bit_cnt=0, state=FILL, out_valid<=0, rej_cnt=0.
  - No bits are generated in the load cycle.
- An all-zero LFSR state is unreachable, since both the reset value and every loaded value are non-zero.
- out_data changes only on an accepted-word load. It is never modified while out_valid=1 and out_ready=0.
- Reset asserted mid-word or in STALL returns immediately to the reset values; the partial word is lost.

Decomposition:
- Shared package rng_pkg:
  - State enum (FILL, STALL).
  - Default TAPS constants for lengths 8, 16 and 32 (8'hB8, 16'hB400, 32'h80200003).
  - Default RESET_SEED.
- Sub-module lfsr_core (parameters LFSR_W, TAPS, STEPS):
  - Combinational next-state for STEPS steps plus the STEPS-bit output vector.
  - Reused by future noise and shuffle blocks.
- The top level holds the assembly register, the FSM, the output register and rej_cnt.

Test Plan:
1. Reset, en=1, out_ready=1, limit=6'h3F, defaults → first out_valid at edge 6, then one word per 6 cycles; words match the bench LFSR model seeded with 16'hACE1.
2. seed_load with seed=16'h0000 → internal lfsr=16'h0001, out_valid=0, rej_cnt=0; the next 10 words match the model seeded with 1. A second load of 16'h1234 repeated twice gives identical 10-word sequences.
3. out_ready=0 for 20 cycles → out_data stable and out_valid=1, FSM enters STALL after one further word; on release, the two words are delivered in order with no loss.
4. limit=6'd0 → every delivered out_data=0; rej_cnt increments once per rejected candidate and saturates at 255 after sufficient run time.
5. STEPS=3, WIDTH=6 → one word every 2 cycles; bit order matches the model.
6. rst_n pulsed low mid-word and during STALL → outputs return to 0 asynchronously; the sequence restarts identically to scenario 1.

Source files
------------

// File: rtl/rng_pkg.sv
// Shared types and default constants for the random-word generator family.
package rng_pkg;

   typedef enum logic {
      FILL  = 1'b0,
      STALL = 1'b1
   } state_t;

   localparam logic [7:0]  TAPS_8       = 8'hB8;
   localparam logic [15:0] TAPS_16      = 16'hB400;
   localparam logic [31:0] TAPS_32      = 32'h80200003;
   localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/lfsr_core.sv
// Combinational Fibonacci LFSR advancing STEPS times; bits_o[STEPS-1] is the earliest bit.
module lfsr_core #(
   parameter int unsigned           LFSR_W = 16,
   parameter logic [LFSR_W-1:0]     TAPS   = 16'hB400,
   parameter int unsigned           STEPS  = 1
) (
   input  logic [LFSR_W-1:0] state_i,
   output logic [LFSR_W-1:0] next_o,
   output logic [STEPS-1:0]  bits_o
);

   always_comb begin
      logic [LFSR_W-1:0] s;
      logic              fb;
      s      = state_i;
      fb     = 1'b0;
      bits_o = '0;
      for (int unsigned i = 0; i < STEPS; i++) begin
         fb                 = ^(s & TAPS);
         s                  = {s[LFSR_W-2:0], fb};
         bits_o[STEPS-1-i]  = fb;
      end
      next_o = s;
   end

endmodule

// File: rtl/rng_word_gen.sv
// Assembles LFSR bits into WIDTH-bit words, rejects words above limit and
// delivers accepted words over a valid/ready handshake.
module rng_word_gen
   import rng_pkg::*;
#(
   parameter int unsigned       WIDTH      = 6,
   parameter int unsigned       LFSR_W     = 16,
   parameter logic [LFSR_W-1:0] TAPS       = LFSR_W'(TAPS_16),
   parameter int unsigned       STEPS      = 1,
   parameter logic [LFSR_W-1:0] RESET_SEED = LFSR_W'(DEFAULT_SEED)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              seed_load,
   input  logic [LFSR_W-1:0] seed,
   input  logic [WIDTH-1:0]  limit,
   output logic [WIDTH-1:0]  out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [7:0]        rej_cnt
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   logic [LFSR_W-1:0]      lfsr_q, lfsr_d;
   logic [STEPS-1:0]       gen_bits;
   logic [WIDTH-1:0]       acc_q, acc_d;
   logic [WIDTH+STEPS-1:0] shift_w;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0]       out_data_q;
   logic                   out_valid_q;
   logic [7:0]             rej_q;
   state_t                 state_q;
   logic                   hs;
   logic                   word_done;
   logic [LFSR_W-1:0]      seed_val;

   lfsr_core #(
      .LFSR_W (LFSR_W),
      .TAPS   (TAPS),
      .STEPS  (STEPS)
   ) u_lfsr (
      .state_i (lfsr_q),
      .next_o  (lfsr_d),
      .bits_o  (gen_bits)
   );

   // Concatenate before slicing so WIDTH == STEPS needs no special case.
   assign shift_w   = {acc_q, gen_bits};
   assign acc_d     = shift_w[WIDTH-1:0];
   assign cnt_d     = cnt_q + CNT_W'(STEPS);
   assign word_done = (cnt_d == CNT_W'(WIDTH));
   assign hs        = out_valid_q & out_ready;
   assign seed_val  = (seed == '0) ? LFSR_W'(1) : seed;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q      <= RESET_SEED;
         acc_q       <= '0;
         cnt_q       <= '0;
         state_q     <= FILL;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         rej_q       <= '0;
      end else if (seed_load) begin
         lfsr_q      <= seed_val;
         acc_q       <= '0;
         cnt_q       <= '0;
         state_q     <= FILL;
         out_valid_q <= 1'b0;
         rej_q       <= '0;
      end else begin
         case (state_q)
            FILL: begin
               if (hs) out_valid_q <= 1'b0;
               if (en) begin
                  lfsr_q <= lfsr_d;
                  acc_q  <= acc_d;
                  if (!word_done) begin
                     cnt_q <= cnt_d;
                  end else begin
                     cnt_q <= '0;
                     if (acc_d > limit) begin
                        rej_q <= sat_inc8(rej_q);
                     end else if (!out_valid_q || hs) begin
                        out_data_q  <= acc_d;
                        out_valid_q <= 1'b1;
                     end else begin
                        // acc_q keeps the candidate while stalled
                        state_q <= STALL;
                     end
                  end
               end
            end
            STALL: begin
               if (hs) begin
                  out_data_q <= acc_q;
                  state_q    <= FILL;
               end
            end
            default: state_q <= FILL;
         endcase
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign rej_cnt   = rej_q;

endmodule

// File: tb/tb_rng_word_gen.sv
// Directed bench for rng_word_gen: default STEPS=1 instance and a STEPS=3 instance.
module tb_rng_word_gen;
   import rng_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n, en, seed_load, out_ready;
   logic [15:0] seed;
   logic [5:0]  limit;
   logic [5:0]  d1, d3;
   logic        v1, v3;
   logic [7:0]  r1, r3;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   logic [15:0] m;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   rng_word_gen dut1 (
      .clk(clk), .rst_n(rst_n), .en(en), .seed_load(seed_load), .seed(seed),
      .limit(limit), .out_data(d1), .out_valid(v1), .out_ready(out_ready), .rej_cnt(r1)
   );

   rng_word_gen #(
      .WIDTH(6), .LFSR_W(16), .TAPS(16'hB400), .STEPS(3), .RESET_SEED(16'hACE1)
   ) dut3 (
      .clk(clk), .rst_n(rst_n), .en(en), .seed_load(seed_load), .seed(seed),
      .limit(limit), .out_data(d3), .out_valid(v3), .out_ready(out_ready), .rej_cnt(r3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model: taps 15,13,12,10, earliest bit lands at the word MSB.
   task automatic model_word(output logic [5:0] w);
      logic fb;
      w = '0;
      for (int i = 0; i < 6; i++) begin
         fb = m[15] ^ m[13] ^ m[12] ^ m[10];
         m  = {m[14:0], fb};
         w  = {w[4:0], fb};
      end
   endtask

   task automatic get_word(input bit use3, output logic [5:0] w, output int at);
      int n;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!(use3 ? v3 : v1) && n < 60);
      chk("word_timeout", 32'(use3 ? v3 : v1), 32'd1);
      w  = use3 ? d3 : d1;
      at = cyc;
   endtask

   task automatic load(input logic [15:0] s);
      @(posedge clk); #1;
      seed = s; seed_load = 1'b1;
      @(posedge clk); #1;
      seed_load = 1'b0;
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      logic [5:0] w, e, e2, e3;
      logic [5:0] seq_a [10];
      int at, last, exp_rej, zeros, vcount, bad;

      rst_n = 1'b1; en = 1'b1; seed_load = 1'b0; seed = '0;
      limit = 6'h3F; out_ready = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_data", 32'(d1), 32'd0);
      chk("rst_valid", 32'(v1), 32'd0);
      chk("rst_rej", 32'(r1), 32'd0);

      // 1: first word at edge 6, then one every 6 cycles
      cycles(2);
      rst_n = 1'b1;
      last = cyc;
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk); #1;
         chk("s1_latency", 32'(v1), 32'(k == 6));
      end
      chk("s1_word0_hand", 32'(d1), 32'h39);
      m = 16'hACE1;
      model_word(e);
      chk("s1_word0_model", 32'(d1), 32'(e));
      last = cyc;
      for (int i = 0; i < 4; i++) begin
         get_word(1'b0, w, at);
         model_word(e);
         chk("s1_word", 32'(w), 32'(e));
         chk("s1_spacing", 32'(at - last), 32'd6);
         last = at;
      end

      // 2: zero seed becomes 1; repeated seed gives repeated sequence
      load(16'h0000);
      chk("s2_lfsr_guard", 32'(dut1.lfsr_q), 32'h0001);
      chk("s2_valid", 32'(v1), 32'd0);
      chk("s2_rej", 32'(r1), 32'd0);
      m = 16'h0001;
      for (int i = 0; i < 10; i++) begin
         get_word(1'b0, w, at);
         model_word(e);
         chk("s2_seed1_word", 32'(w), 32'(e));
      end
      load(16'h1234);
      m = 16'h1234;
      for (int i = 0; i < 10; i++) begin
         get_word(1'b0, w, at);
         model_word(e);
         seq_a[i] = w;
         chk("s2_1234_a", 32'(w), 32'(e));
      end
      load(16'h1234);
      for (int i = 0; i < 10; i++) begin
         get_word(1'b0, w, at);
         chk("s2_1234_repeat", 32'(w), 32'(seq_a[i]));
      end

      // 3: backpressure, stall, ordered release
      out_ready = 1'b0;
      load(16'h1234);
      m = 16'h1234;
      model_word(e); model_word(e2); model_word(e3);
      get_word(1'b0, w, at);
      chk("s3_w1", 32'(w), 32'(e));
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (d1 !== e || v1 !== 1'b1) bad++;
      end
      chk("s3_hold_stable", 32'(bad), 32'd0);
      chk("s3_in_stall", 32'(dut1.state_q), 32'(STALL));
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("s3_w2_data", 32'(d1), 32'(e2));
      chk("s3_w2_valid", 32'(v1), 32'd1);
      get_word(1'b0, w, at);
      chk("s3_w3", 32'(w), 32'(e3));

      // 4: limit boundaries and saturating reject counter
      limit = 6'h38;
      load(16'hACE1);
      cycles(6);
      chk("s4_below_rej", 32'(r1), 32'd1);
      chk("s4_below_valid", 32'(v1), 32'd0);
      limit = 6'h39;
      load(16'hACE1);
      cycles(6);
      chk("s4_equal_valid", 32'(v1), 32'd1);
      chk("s4_equal_data", 32'(d1), 32'h39);
      chk("s4_equal_rej", 32'(r1), 32'd0);
      limit = 6'd0;
      load(16'hACE1);
      m = 16'hACE1;
      exp_rej = 0; zeros = 0; vcount = 0; bad = 0;
      for (int c = 0; c < 300; c++) begin
         model_word(e);
         if (e != 6'd0) begin
            if (exp_rej < 255) exp_rej++;
         end else begin
            zeros++;
         end
         for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (v1) begin
               vcount++;
               if (d1 !== 6'd0) bad++;
            end
         end
         if (c < 3) chk("s4_rej_step", 32'(r1), 32'(exp_rej));
      end
      chk("s4_rej_sat", 32'(r1), 32'(exp_rej));
      chk("s4_rej_is_255", 32'(r1), 32'd255);
      chk("s4_zero_words", 32'(bad), 32'd0);
      chk("s4_accept_count", 32'(vcount), 32'(zeros));

      // 5: STEPS=3 gives a word every 2 cycles with the same bit order
      limit = 6'h3F;
      load(16'hACE1);
      m = 16'hACE1;
      last = cyc;
      for (int i = 0; i < 10; i++) begin
         get_word(1'b1, w, at);
         model_word(e);
         chk("s5_word", 32'(w), 32'(e));
         chk("s5_spacing", 32'(at - last), 32'd2);
         last = at;
      end
      chk("s5_first_hand", 32'(seq_a[0]), 32'(seq_a[0]) ^ 32'(w) ^ 32'(e));

      // 6: async reset mid-word and during stall
      load(16'h0042);
      cycles(3);
      rst_n = 1'b0;
      #1;
      chk("s6_mid_data", 32'(d1), 32'd0);
      chk("s6_mid_valid", 32'(v1), 32'd0);
      chk("s6_mid_rej", 32'(r1), 32'd0);
      chk("s6_mid_data3", 32'(d3), 32'd0);
      cycles(2);
      rst_n = 1'b1;
      m = 16'hACE1;
      last = cyc;
      for (int i = 0; i < 3; i++) begin
         get_word(1'b0, w, at);
         model_word(e);
         chk("s6_restart_word", 32'(w), 32'(e));
         if (i == 0) chk("s6_restart_lat", 32'(at - last), 32'd6);
      end
      out_ready = 1'b0;
      get_word(1'b0, w, at);
      cycles(8);
      chk("s6_stall_state", 32'(dut1.state_q), 32'(STALL));
      rst_n = 1'b0;
      #1;
      chk("s6_stall_data", 32'(d1), 32'd0);
      chk("s6_stall_valid", 32'(v1), 32'd0);
      chk("s6_stall_fsm", 32'(dut1.state_q), 32'(FILL));
      cycles(2);
      out_ready = 1'b1;
      rst_n = 1'b1;
      last = cyc;
      get_word(1'b0, w, at);
      chk("s6_stall_restart", 32'(w), 32'h39);
      chk("s6_stall_lat", 32'(at - last), 32'd6);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
